// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Two-client round-robin arbiter and sequencer in front of the
//            multi-cycle dummy_mem. Handles one transaction at a time and
//            returns read data with a done pulse.
// Options  : MEM_ARB_TIMEOUT_EN - enables the RD/WR watchdog (TIMEOUT_CYCLES)
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0_valid,
  input  logic          req0_we,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_wdata,
  output logic          req0_grant,
  output logic          req0_done,
  input  logic          req1_valid,
  input  logic          req1_we,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_wdata,
  output logic          req1_grant,
  output logic          req1_done,
  output logic [DW-1:0] rdata,
  output logic          mem_re,
  output logic          mem_we,
  output logic [AW-1:0] mem_r_addr,
  output logic [AW-1:0] mem_w_addr,
  output logic [DW-1:0] mem_d_in,
  input  logic [DW-1:0] mem_d_out,
  input  logic          mem_r_finished,
  input  logic          mem_w_finished,
  output logic          busy,
  output logic          timeout_err
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD    = 3'd1,
    ST_WR    = 3'd2,
    ST_DONE  = 3'd3,
    ST_DRAIN = 3'd4
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_id;       // requester owning the current transaction
  logic          r_last;     // requester granted most recently
  logic          r_grant0;
  logic          r_grant1;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_rdata;
  logic          w_any;
  logic          w_pick;     // 0 = requester 0 wins, 1 = requester 1 wins
  logic          w_pick_we;
  logic          w_xfer;     // in RD or WR
  logic          w_fin;      // finished flag matching the current type
  logic          w_tmo;

  assign w_any     = req0_valid | req1_valid;
  assign w_pick_we = w_pick ? req1_we : req0_we;
  assign w_xfer    = (r_state == ST_RD) || (r_state == ST_WR);
  assign w_fin     = (r_state == ST_RD) ? mem_r_finished : mem_w_finished;

  // Winner selection: a lone requester wins, contention goes to the one not granted last
  always_comb begin
    w_pick = 1'b0;
    if (req0_valid && req1_valid) begin
      w_pick = ~r_last;
    end else if (req1_valid) begin
      w_pick = 1'b1;
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] r_cnt;
  logic          r_tmo_err;

  assign w_tmo       = w_xfer && (r_cnt == CW'(TIMEOUT_CYCLES));
  assign timeout_err = r_tmo_err;

  // Watchdog: cleared while idle so it starts at zero on RD/WR entry; sticky error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_tmo_err <= 1'b0;
    end else begin
      if (r_state == ST_IDLE) begin
        r_cnt <= '0;
      end else if (w_xfer) begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (w_tmo && !w_fin) begin
        r_tmo_err <= 1'b1;
      end
    end
  end
`else
  assign w_tmo       = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and state-decoded outputs; memory strobes drop as soon as reset forces IDLE
  always_comb begin
    w_state_nxt = r_state;
    mem_re      = 1'b0;
    mem_we      = 1'b0;
    req0_done   = 1'b0;
    req1_done   = 1'b0;
    busy        = (r_state != ST_IDLE);
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_state_nxt = w_pick_we ? ST_WR : ST_RD;
        end
      end
      ST_RD: begin
        mem_re = 1'b1;
        if (w_fin || w_tmo) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_WR: begin
        mem_we = 1'b1;
        if (w_fin || w_tmo) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        req0_done   = ~r_id;
        req1_done   = r_id;
        w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!mem_r_finished && !mem_w_finished) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Request capture, grant pulses, round-robin pointer and read-data capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_id     <= 1'b0;
      r_last   <= 1'b1;
      r_grant0 <= 1'b0;
      r_grant1 <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
    end else begin
      r_grant0 <= 1'b0;
      r_grant1 <= 1'b0;
      if ((r_state == ST_IDLE) && w_any) begin
        r_id     <= w_pick;
        r_last   <= w_pick;
        r_grant0 <= ~w_pick;
        r_grant1 <= w_pick;
        r_addr   <= w_pick ? req1_addr  : req0_addr;
        r_wdata  <= w_pick ? req1_wdata : req0_wdata;
      end
      if ((r_state == ST_RD) && mem_r_finished) begin
        r_rdata <= mem_d_out;
      end else if (w_tmo) begin
        r_rdata <= '0;
      end
    end
  end

  assign req0_grant = r_grant0;
  assign req1_grant = r_grant1;
  assign rdata      = r_rdata;
  assign mem_r_addr = r_addr;
  assign mem_w_addr = r_addr;
  assign mem_d_in   = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Directed self-checking bench for mem_arbiter (reset, read, write,
//            round-robin, drain, optional watchdog with MEM_ARB_TIMEOUT_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0_valid, req0_we, req0_grant, req0_done;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_wdata;
  logic          req1_valid, req1_we, req1_grant, req1_done;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_wdata;
  logic [DW-1:0] rdata;
  logic          mem_re, mem_we;
  logic [AW-1:0] mem_r_addr, mem_w_addr;
  logic [DW-1:0] mem_d_in, mem_d_out;
  logic          mem_r_finished, mem_w_finished;
  logic          busy, timeout_err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(
    .AW             (AW),
    .DW             (DW),
    .TIMEOUT_CYCLES (8)
  ) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req0_valid     (req0_valid),
    .req0_we        (req0_we),
    .req0_addr      (req0_addr),
    .req0_wdata     (req0_wdata),
    .req0_grant     (req0_grant),
    .req0_done      (req0_done),
    .req1_valid     (req1_valid),
    .req1_we        (req1_we),
    .req1_addr      (req1_addr),
    .req1_wdata     (req1_wdata),
    .req1_grant     (req1_grant),
    .req1_done      (req1_done),
    .rdata          (rdata),
    .mem_re         (mem_re),
    .mem_we         (mem_we),
    .mem_r_addr     (mem_r_addr),
    .mem_w_addr     (mem_w_addr),
    .mem_d_in       (mem_d_in),
    .mem_d_out      (mem_d_out),
    .mem_r_finished (mem_r_finished),
    .mem_w_finished (mem_w_finished),
    .busy           (busy),
    .timeout_err    (timeout_err)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge
  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    logic        flag;
    logic        seen;
    int          n_gr, n_dn, overlap, lat;
    int          gcyc [4];
    logic [3:0]  seq;

    rst_n = 1'b0;
    req0_valid = 1'b0; req0_we = 1'b0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 1'b0; req1_we = 1'b0; req1_addr = '0; req1_wdata = '0;
    mem_d_out = '0; mem_r_finished = 1'b0; mem_w_finished = 1'b0;

    // Reset state
    tick();
    check("reset_ctrl", {req0_grant, req1_grant, req0_done, req1_done,
                         mem_re, mem_we, busy, timeout_err}, 64'h0);
    check("reset_data", {rdata, mem_r_addr}, 64'h0);
    rst_n = 1'b1;
    tick();

    // 1: reset in the middle of a write
    req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 32'h100; req0_wdata = 32'h55;
    tick();
    check("t1_grant_we", {req0_grant, mem_we}, 64'h3);
    req0_valid = 1'b0;
    tick(); tick();
    #2 rst_n = 1'b0;
    #1 check("t1_async_drop", {mem_we, busy}, 64'h0);
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      tick();
      seen |= req0_done | req1_done | busy;
    end
    check("t1_no_done", seen, 1'b0);

    // 2: requester 0 read, memory answers after 20 cycles
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 32'hABCDABCD;
    tick();
    check("t2_grant", {req0_grant, req1_grant, mem_re, mem_we}, 64'b1010);
    check("t2_addr", mem_r_addr, 32'hABCDABCD);
    req0_valid = 1'b0;
    flag = 1'b1;
    repeat (19) begin
      tick();
      flag &= mem_re && (mem_r_addr == 32'hABCDABCD) && !req0_done && !req0_grant;
    end
    check("t2_stable", flag, 1'b1);
    mem_d_out = 32'h12345678; mem_r_finished = 1'b1;
    tick();
    check("t2_done", {req0_done, req1_done, mem_re, req0_grant}, 64'b1000);
    check("t2_rdata", rdata, 32'h12345678);
    mem_d_out = '0; mem_r_finished = 1'b0;
    tick();
    check("t2_done_pulse", {req0_done, busy}, 64'b01);
    tick();
    check("t2_idle", busy, 1'b0);

    // 3: requester 1 write, a read-finished level meanwhile must be ignored
    req1_valid = 1'b1; req1_we = 1'b1; req1_addr = 32'hFFFFFFFF; req1_wdata = 32'hDEADBEEF;
    seen = 1'b0;
    tick();
    check("t3_grant", {req1_grant, req0_grant, mem_we}, 64'b101);
    check("t3_bus", {mem_w_addr, mem_d_in}, 64'hFFFFFFFF_DEADBEEF);
    req1_valid = 1'b0;
    mem_r_finished = 1'b1;
    flag = 1'b1;
    repeat (5) begin
      tick();
      seen |= mem_re;
      flag &= mem_we && (mem_w_addr == 32'hFFFFFFFF) && (mem_d_in == 32'hDEADBEEF) && !req1_done;
    end
    check("t3_stable", flag, 1'b1);
    mem_r_finished = 1'b0; mem_w_finished = 1'b1;
    tick();
    seen |= mem_re;
    check("t3_done", {req1_done, req0_done, mem_we}, 64'b100);
    check("t3_rdata_held", rdata, 32'h12345678);
    mem_w_finished = 1'b0;
    tick(); seen |= mem_re;
    tick(); seen |= mem_re;
    check("t3_idle_no_re", {busy, seen}, 64'b00);

    // 4: both requesters contend continuously; memory answers immediately
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 32'h10;
    req1_valid = 1'b1; req1_we = 1'b1; req1_addr = 32'h20; req1_wdata = 32'h2;
    n_gr = 0; n_dn = 0; overlap = 0; seq = '0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      tick();
      if ((req0_grant || req1_grant) && (req0_done || req1_done)) overlap++;
      if (req0_grant && req1_grant) overlap++;
      if ((req0_grant || req1_grant) && n_gr < 4) begin
        seq[n_gr]  = req1_grant;
        gcyc[n_gr] = cyc;
        n_gr++;
        if (n_gr == 4) begin
          req0_valid = 1'b0; req1_valid = 1'b0;
        end
      end
      if (req0_done || req1_done) n_dn++;
      mem_r_finished = mem_re;
      mem_w_finished = mem_we;
      if (n_gr == 4 && n_dn == 4 && !busy) break;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    mem_r_finished = 1'b0; mem_w_finished = 1'b0;
    check("t4_counts", {n_gr[15:0], n_dn[15:0]}, {16'd4, 16'd4});
    check("t4_order", seq, 4'b1010);
    check("t4_overlap", overlap, 0);
    check("t4_spacing", {gcyc[1] - gcyc[0], gcyc[3] - gcyc[2]}, {32'd4, 32'd4});
    tick();

    // 5: finished held high in DRAIN, pending request waits; dropped valid is ignored
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 32'h300;
    tick();
    check("t5_grant0", req0_grant, 1'b1);
    req0_valid = 1'b0;
    mem_r_finished = 1'b1; mem_d_out = 32'h5A5A;
    tick();
    check("t5_done0", {req0_done, rdata}, {1'b1, 32'h5A5A});
    req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 32'h400;
    req0_valid = 1'b1;
    flag = 1'b1;
    repeat (3) begin
      tick();
      flag &= busy && !req0_grant && !req1_grant && !mem_re;
    end
    check("t5_drain_hold", flag, 1'b1);
    mem_r_finished = 1'b0; req0_valid = 1'b0;
    tick();
    check("t5_idle", {busy, req1_grant}, 64'b00);
    tick();
    check("t5_grant1", {req1_grant, req0_grant, mem_re}, 64'b101);
    check("t5_addr1", mem_r_addr, 32'h400);
    req1_valid = 1'b0;
    mem_w_finished = 1'b1;
    tick(); tick();
    check("t5_wrong_type", {mem_re, req1_done}, 64'b10);
    mem_w_finished = 1'b0; mem_r_finished = 1'b1; mem_d_out = 32'h77;
    tick();
    check("t5_done1", {req1_done, req0_done, rdata}, {1'b1, 1'b0, 32'h77});
    mem_r_finished = 1'b0;
    tick(); tick();
    check("t5_idle_end", busy, 1'b0);

`ifdef MEM_ARB_TIMEOUT_EN
    // 6: memory never answers; watchdog completes the read
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 32'h600;
    tick();
    check("t6_grant", req0_grant, 1'b1);
    req0_valid = 1'b0;
    lat = 0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (req0_done) begin
        lat = k;
        break;
      end
    end
    check("t6_latency", lat, 9);
    check("t6_rdata_zero", rdata, 32'h0);
    check("t6_err_set", timeout_err, 1'b1);
    tick(); tick();
    check("t6_err_sticky", {timeout_err, busy}, 64'b10);
    rst_n = 1'b0;
    tick();
    check("t6_err_reset", timeout_err, 1'b0);
    rst_n = 1'b1;
    tick();
`else
    lat = 0;
    check("t6_err_tied", {timeout_err, lat[0]}, 64'b00);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
